// File: rtl/alu64_pkg.sv
// Shared constants for the 64-bit flag-setting ALU: operand width and op codes.
package alu64_pkg;
    localparam int ALU_W = 64;

    localparam logic [2:0] OP_PASSB = 3'b000;
    localparam logic [2:0] OP_RSV1  = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_AND   = 3'b100;
    localparam logic [2:0] OP_OR    = 3'b101;
    localparam logic [2:0] OP_XOR   = 3'b110;
    localparam logic [2:0] OP_RSV7  = 3'b111;
endpackage

// File: rtl/alu_bitslice.sv
// One bit of the ALU: full adder with optional B inversion, plus bitwise logic ops.
module alu_bitslice
    import alu64_pkg::*;
(
    input  logic       a_i,
    input  logic       b_i,
    input  logic       cin_i,
    input  logic       binv_i,
    input  logic [2:0] op_i,
    output logic       res_o,
    output logic       cout_o
);
    logic bx;
    logic sum;

    assign bx     = b_i ^ binv_i;
    assign sum    = a_i ^ bx ^ cin_i;
    assign cout_o = (a_i & bx) | (a_i & cin_i) | (bx & cin_i);

    always_comb begin
        res_o = 1'b0;
        case (op_i)
            OP_PASSB:       res_o = b_i;
            OP_ADD, OP_SUB: res_o = sum;
            OP_AND:         res_o = a_i & b_i;
            OP_OR:          res_o = a_i | b_i;
            OP_XOR:         res_o = a_i ^ b_i;
            default:        res_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/alu64_flag_unit.sv
// 64-bit ripple-carry ALU with live NZVC flags and an enable-gated stored flag register.
// Define ALU64_RESULT_REG_EN to register the result output (1-cycle latency).
module alu64_flag_unit
    import alu64_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  logic [2:0]       cntrl,
    input  logic             set_flg,
    output logic [ALU_W-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out,
    output logic             n_flag,
    output logic             z_flag,
    output logic             v_flag,
    output logic             c_flag
);
    logic [ALU_W:0]   carry;
    logic [ALU_W-1:0] res_comb;
    logic             is_sub;
    logic             is_arith;
    logic [3:0]       flags_d, flags_q;

    // Subtraction is A + ~B + 1: invert B in every slice and seed the chain with 1.
    assign is_sub   = (cntrl == OP_SUB);
    assign is_arith = (cntrl == OP_ADD) || is_sub;
    assign carry[0] = is_sub;

    genvar i;
    generate
        for (i = 0; i < ALU_W; i++) begin : g_slice
            alu_bitslice u_slice (
                .a_i    (a[i]),
                .b_i    (b[i]),
                .cin_i  (carry[i]),
                .binv_i (is_sub),
                .op_i   (cntrl),
                .res_o  (res_comb[i]),
                .cout_o (carry[i+1])
            );
        end
    endgenerate

    assign negative  = res_comb[ALU_W-1];
    assign zero      = (res_comb == '0);
    assign carry_out = is_arith & carry[ALU_W];
    assign overflow  = is_arith & (carry[ALU_W-1] ^ carry[ALU_W]);

    always_comb begin
        flags_d = flags_q;
        if (set_flg)
            flags_d = {negative, zero, overflow, carry_out};
    end

    always_ff @(posedge clk) begin
        if (reset)
            flags_q <= 4'b0000;
        else
            flags_q <= flags_d;
    end

    assign {n_flag, z_flag, v_flag, c_flag} = flags_q;

`ifdef ALU64_RESULT_REG_EN
    logic [ALU_W-1:0] res_d, res_q;

    assign res_d = res_comb;

    always_ff @(posedge clk) begin
        if (reset)
            res_q <= '0;
        else
            res_q <= res_d;
    end

    assign result = res_q;
`else
    assign result = res_comb;
`endif
endmodule

// File: tb/tb_alu64_flag_unit.sv
// Directed-vector bench for alu64_flag_unit; handles both result-register build options.
module tb_alu64_flag_unit;
    import alu64_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] a, b;
    logic [2:0]  cntrl;
    logic        set_flg;
    logic [63:0] result;
    logic        negative, zero, overflow, carry_out;
    logic        n_flag, z_flag, v_flag, c_flag;

    int n_chk  = 0;
    int n_pass = 0;

    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;

    always #5 clk = ~clk;

    alu64_flag_unit dut (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .b         (b),
        .cntrl     (cntrl),
        .set_flg   (set_flg),
        .result    (result),
        .negative  (negative),
        .zero      (zero),
        .overflow  (overflow),
        .carry_out (carry_out),
        .n_flag    (n_flag),
        .z_flag    (z_flag),
        .v_flag    (v_flag),
        .c_flag    (c_flag)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got %h exp %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Apply one vector, check live flags and result, clock it, check stored flags.
    task automatic vec(input string tag, input logic [63:0] va, input logic [63:0] vb,
                       input logic [2:0] op, input logic sf, input logic [63:0] exp_res,
                       input logic [3:0] exp_live, input logic [3:0] exp_st);
        a = va; b = vb; cntrl = op; set_flg = sf;
        #1;
        chk({tag, ".live"}, {60'd0, negative, zero, overflow, carry_out}, {60'd0, exp_live});
`ifndef ALU64_RESULT_REG_EN
        chk({tag, ".res"}, result, exp_res);
`endif
        step();
`ifdef ALU64_RESULT_REG_EN
        chk({tag, ".res"}, result, exp_res);
`endif
        chk({tag, ".st"}, {60'd0, n_flag, z_flag, v_flag, c_flag}, {60'd0, exp_st});
    endtask

    initial begin
        reset = 1'b1; set_flg = 1'b1; a = ALL1; b = ALL1; cntrl = OP_ADD;
        step();
        chk("rst0.st", {60'd0, n_flag, z_flag, v_flag, c_flag}, 64'd0);
        step();
        chk("rst1.st", {60'd0, n_flag, z_flag, v_flag, c_flag}, 64'd0);
`ifdef ALU64_RESULT_REG_EN
        chk("rst.res", result, 64'd0);
`endif
        reset = 1'b0;

        //   tag        a        b        op        sf    result                  live NZVC stored NZVC
        vec("add_cz",   ALL1,    64'd1,   OP_ADD,   1'b1, 64'd0,                  4'b0101, 4'b0101);
        vec("add_ov",   MAXP,    64'd1,   OP_ADD,   1'b1, MINN,                   4'b1010, 4'b1010);
        vec("sub_brw",  64'd3,   64'd5,   OP_SUB,   1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 4'b1000);
        vec("sub_nb",   64'd5,   64'd3,   OP_SUB,   1'b1, 64'd2,                  4'b0001, 4'b0001);
        vec("sub_eq",   64'd5,   64'd5,   OP_SUB,   1'b1, 64'd0,                  4'b0101, 4'b0101);
        vec("sub_ov",   MINN,    64'd1,   OP_SUB,   1'b1, MAXP,                   4'b0011, 4'b0011);
        vec("and",      64'hF0F0, 64'h0FF0, OP_AND,  1'b1, 64'h00F0,              4'b0000, 4'b0000);
        vec("or",       64'hF0F0, 64'h0FF0, OP_OR,   1'b1, 64'hFFF0,              4'b0000, 4'b0000);
        vec("xor",      64'hF0F0, 64'h0FF0, OP_XOR,  1'b1, 64'hFF00,              4'b0000, 4'b0000);
        vec("passb",    64'hF0F0, 64'h0FF0, OP_PASSB,1'b1, 64'h0FF0,              4'b0000, 4'b0000);
        vec("and_neg",  ALL1,    MINN,    OP_AND,   1'b1, MINN,                   4'b1000, 4'b1000);
        vec("rsv7",     64'hF0F0, 64'h0FF0, OP_RSV7, 1'b1, 64'd0,                 4'b0100, 4'b0100);
        vec("rsv1",     ALL1,    ALL1,    OP_RSV1,  1'b1, 64'd0,                  4'b0100, 4'b0100);

        // Flags loaded once, then held while operands move
        vec("hold_ld",  64'd5,   64'd3,   OP_SUB,   1'b1, 64'd2,                  4'b0001, 4'b0001);
        vec("hold1",    ALL1,    64'd1,   OP_ADD,   1'b0, 64'd0,                  4'b0101, 4'b0001);
        vec("hold2",    MAXP,    64'd1,   OP_ADD,   1'b0, MINN,                   4'b1010, 4'b0001);
        vec("hold3",    64'd3,   64'd5,   OP_SUB,   1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 4'b0001);

        // Reset wins over a pending flag update
        reset = 1'b1; set_flg = 1'b1; a = MAXP; b = 64'd1; cntrl = OP_ADD;
        step();
        chk("rst_mid.st", {60'd0, n_flag, z_flag, v_flag, c_flag}, 64'd0);
`ifdef ALU64_RESULT_REG_EN
        chk("rst_mid.res", result, 64'd0);
`endif
        reset = 1'b0;
        vec("post_rst", 64'd5,   64'd3,   OP_SUB,   1'b1, 64'd2,                  4'b0001, 4'b0001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
